// File: rtl/seq_div8.sv
// -----------------------------------------------------------------------------
// seq_div8 -- multi-cycle unsigned restoring divider for the ALU.
//
// Each cycle in CALC resolves one quotient bit. The remainder is shifted left,
// taking in the next dividend bit, and the divisor is trial-subtracted from it.
// If the subtraction does not borrow, its result is kept. Otherwise the shifted
// remainder is kept unchanged (the "restore" step).
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset (returns to IDLE from any state)
//   start        request; sampled only while IDLE
//   dividend     numerator, captured on an accepted start
//   divisor      denominator, captured on an accepted start
//   quotient     result; valid from done until the next result completes
//   remainder    result; valid from done until the next result completes
//   busy         high while iterating (CALC)
//   done         one-cycle completion pulse
//   div_by_zero  set together with done when the captured divisor was zero
//
// Every output is a flop. None of them has a combinational path from an input.
// -----------------------------------------------------------------------------
module seq_div8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] q_work_reg;     // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] r_work_reg;     // partial remainder accumulator
    logic [WIDTH-1:0] divisor_reg;
    logic [CNT_W-1:0] count_reg;
    logic [WIDTH-1:0] quotient_reg, remainder_reg;
    logic             busy_reg, done_reg, div_by_zero_reg;
    logic             busy_next, done_next;

    // One restoring-division step
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] q_iter, r_iter;

    always_comb begin
        r_shift = {r_work_reg[WIDTH-2:0], q_work_reg[WIDTH-1]};
        trial   = {1'b0, r_shift} - {1'b0, divisor_reg};
        if (!trial[WIDTH]) begin
            // No borrow: the divisor fits, so keep the difference and emit a 1.
            r_iter = trial[WIDTH-1:0];
            q_iter = {q_work_reg[WIDTH-2:0], 1'b1};
        end else begin
            r_iter = r_shift;
            q_iter = {q_work_reg[WIDTH-2:0], 1'b0};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = (divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (count_reg == LAST_ITER) begin
                    state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Output logic. busy and done are decoded from the next state and then
    // registered, so that they line up with the state they describe.
    always_comb begin
        busy_next = (state_next == S_CALC);
        done_next = (state_next == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            busy_reg <= busy_next;
            done_reg <= done_next;
        end
    end

    // Datapath. The visible results change only when a division completes.
    // The working registers are separate so that those results hold through IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_work_reg      <= '0;
            r_work_reg      <= '0;
            divisor_reg     <= '0;
            count_reg       <= '0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            q_work_reg      <= dividend;
                            r_work_reg      <= '0;
                            divisor_reg     <= divisor;
                            count_reg       <= '0;
                            div_by_zero_reg <= 1'b0;
                        end else begin
                            quotient_reg    <= '1;
                            remainder_reg   <= dividend;
                            div_by_zero_reg <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    q_work_reg <= q_iter;
                    r_work_reg <= r_iter;
                    count_reg  <= count_reg + 1'b1;
                    if (count_reg == LAST_ITER) begin
                        quotient_reg  <= q_iter;
                        remainder_reg <= r_iter;
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_seq_div8.sv
// -----------------------------------------------------------------------------
// tb_seq_div8 -- self-checking bench for seq_div8 (WIDTH = 8).
// Directed vectors with hand-computed results, then a strided operand sweep
// checked against the / and % operators. Prints one line per transaction.
// -----------------------------------------------------------------------------
module tb_seq_div8;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] dividend, divisor;
    logic [7:0] quotient, remainder;
    logic       busy, done, div_by_zero;

    int n_vec  = 0;
    int n_miss = 0;

    seq_div8 #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .quotient   (quotient),
        .remainder  (remainder),
        .busy       (busy),
        .done       (done),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Call this at a negedge while the divider is IDLE. It drives start for
    // one cycle and waits (bounded) for done. It checks latency, busy length,
    // the results, and that done is a single-cycle pulse. It returns at the
    // negedge of the IDLE cycle after done, so a following call issues a
    // back-to-back start.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic edz);
        int  lat;
        int  busy_cnt;
        bit  seen;
        lat      = 0;
        busy_cnt = 0;
        seen     = 0;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1;
                lat  = c;
            end
        end
        chk({tag, ".latency"}, lat, (b == 8'd0) ? 1 : 9);
        chk({tag, ".busy_cycles"}, busy_cnt, (b == 8'd0) ? 0 : 8);
        chk({tag, ".quotient"}, int'(quotient), int'(eq));
        chk({tag, ".remainder"}, int'(remainder), int'(er));
        chk({tag, ".div_by_zero"}, int'(div_by_zero), int'(edz));
        $display("txn %s: %0d / %0d -> q=%0d r=%0d dz=%0d lat=%0d", tag, a, b,
                 quotient, remainder, div_by_zero, lat);
        @(negedge clk);
        chk({tag, ".done_pulse_end"}, int'(done), 0);
    endtask

    initial begin
        int  lat;
        bit  seen;
        logic [7:0] a, b, eq, er;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("reset.quotient", int'(quotient), 0);
        chk("reset.remainder", int'(remainder), 0);
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.div_by_zero", int'(div_by_zero), 0);
        @(negedge clk);

        // Basic division and divide-by-zero
        run_div("d200_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0);
        run_div("d5_0", 8'd5, 8'd0, 8'hFF, 8'd5, 1'b1);
        run_div("d255_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0);
        run_div("d0_9", 8'd0, 8'd9, 8'd0, 8'd0, 1'b0);
        run_div("d255_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0);
        run_div("d3_200", 8'd3, 8'd200, 8'd0, 8'd3, 1'b0);
        run_div("d100_10", 8'd100, 8'd10, 8'd10, 8'd0, 1'b0);

        // Reset held 2 cycles mid-CALC clears everything and suppresses done
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("midreset.quotient", int'(quotient), 0);
        chk("midreset.remainder", int'(remainder), 0);
        chk("midreset.busy", int'(busy), 0);
        chk("midreset.done", int'(done), 0);
        chk("midreset.div_by_zero", int'(div_by_zero), 0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done || busy) seen = 1;
        end
        chk("midreset.no_activity", int'(seen), 0);
        $display("txn midreset: reset during CALC, outputs q=%0d r=%0d", quotient, remainder);

        // Re-pulsed start during CALC and in DONE is ignored
        dividend = 8'd100;
        divisor  = 8'd3;
        start    = 1'b1;
        seen     = 0;
        lat      = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 3) begin
                dividend = 8'd10;
                divisor  = 8'd2;
                start    = 1'b1;
            end
            if (done) begin
                seen = 1;
                lat  = c;
            end
        end
        start = 1'b1;  // high across the DONE-cycle edge
        chk("ignore.latency", lat, 9);
        chk("ignore.quotient", int'(quotient), 33);
        chk("ignore.remainder", int'(remainder), 1);
        $display("txn ignore: 100 / 3 with restarts -> q=%0d r=%0d lat=%0d", quotient, remainder, lat);
        @(negedge clk);
        start = 1'b0;
        chk("ignore.done_start_busy", int'(busy), 0);
        @(negedge clk);
        chk("ignore.still_idle", int'(busy), 0);
        chk("ignore.result_held", int'(quotient), 33);
        run_div("after_ignore_10_2", 8'd10, 8'd2, 8'd5, 8'd0, 1'b0);

        // Strided sweep, back-to-back, against the / and % operators
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 256; bi++) begin
                a = 8'(ai * 17);
                b = 8'(bi);
                if (b == 8'd0) begin
                    eq = 8'hFF;
                    er = a;
                end else begin
                    eq = a / b;
                    er = a % b;
                end
                run_div($sformatf("sweep_%0d_%0d", a, b), a, b, eq, er, (b == 8'd0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
